// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_ZERO_MEANS = 256;

  // A length byte of zero encodes the full 256-word image.
  function automatic logic [8:0] decode_len(input logic [7:0] len_byte);
    return (len_byte == 8'h00) ? 9'(LEN_ZERO_MEANS) : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Shifts bytes MSB-first into a 32-bit word; word_full flags that the incoming byte completes it.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic [31:0] packed_word,
  output logic        word_full
);

  // Only the three oldest bytes need storage; the fourth arrives with byte_in.
  logic [23:0] word_q;

  assign packed_word = {word_q, byte_in};
  assign word_full   = (byte_idx == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (shift_en) begin
      word_q   <= packed_word[23:0];
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot sequencer: receives LEN/data/CSUM byte stream, writes words into instruction RAM,
// and releases the CPU from reset only after the checksum verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter bit AUTOSTART = 1'b0,
  parameter int TIMEOUT   = 50000,
  parameter int TO_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wren_instr,
  output logic [7:0]  wraddress_instr,
  output logic [31:0] data_instr,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam state_e RESET_STATE = AUTOSTART ? ST_RUN : ST_IDLE;

  state_e          state, next_state;
  logic [8:0]      len_n;
  logic [7:0]      word_cnt;
  logic [7:0]      csum;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      byte_idx;
  logic [31:0]     packed_word;
  logic            word_full;

  logic accept, counting, timed_out, last_word;

  assign accept    = rx_valid && rx_ready;
  assign counting  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign timed_out = counting && !accept && (to_cnt == TO_W'(TIMEOUT - 1));
  assign last_word = ({1'b0, word_cnt} == (len_n - 9'd1));

  imem_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (state == ST_LEN),
    .shift_en    ((state == ST_DATA) && accept),
    .byte_in     (rx_data),
    .byte_idx    (byte_idx),
    .packed_word (packed_word),
    .word_full   (word_full)
  );

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_LEN;
      ST_LEN:   if (accept) next_state = ST_DATA;
                else if (timed_out) next_state = ST_ERR;
      ST_DATA:  if (accept && word_full) next_state = ST_WRITE;
                else if (timed_out) next_state = ST_ERR;
      ST_WRITE: next_state = last_word ? ST_CSUM : ST_DATA;
      ST_CSUM:  if (accept) next_state = (rx_data == csum) ? ST_RUN : ST_ERR;
                else if (timed_out) next_state = ST_ERR;
      ST_RUN,
      ST_ERR:   if (start) next_state = ST_LEN;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next-state decode, so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RESET_STATE;
      rx_ready        <= 1'b0;
      wren_instr      <= 1'b0;
      wraddress_instr <= '0;
      data_instr      <= '0;
      cpu_reset       <= !AUTOSTART;
      busy            <= 1'b0;
      done            <= AUTOSTART;
      err             <= 1'b0;
      len_n           <= '0;
      word_cnt        <= '0;
      csum            <= '0;
      to_cnt          <= '0;
    end else begin
      state      <= next_state;
      rx_ready   <= (next_state == ST_LEN) || (next_state == ST_DATA) || (next_state == ST_CSUM);
      busy       <= (next_state == ST_LEN) || (next_state == ST_DATA) ||
                    (next_state == ST_WRITE) || (next_state == ST_CSUM);
      wren_instr <= (next_state == ST_WRITE);
      cpu_reset  <= (next_state != ST_RUN);
      done       <= (next_state == ST_RUN);
      err        <= (next_state == ST_ERR);

      if (state == ST_LEN && accept) begin
        len_n    <= decode_len(rx_data);
        word_cnt <= '0;
        csum     <= '0;
      end

      if (state == ST_DATA && accept) begin
        csum <= csum ^ rx_data;
        if (word_full) begin
          data_instr      <= packed_word;
          wraddress_instr <= word_cnt;
        end
      end

      // Wraps to 0 only after the 256th write, when the FSM is already heading to CSUM.
      if (state == ST_WRITE) word_cnt <= word_cnt + 8'd1;

      if (!counting || accept) to_cnt <= '0;
      else                     to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  localparam int TIMEOUT = 20;
  localparam int TO_W    = 16;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, wren_instr, cpu_reset, busy, done, err;
  logic [7:0]  wraddress_instr;
  logic [31:0] data_instr;

  always #5 clk = ~clk;

  imem_loader #(.AUTOSTART(1'b0), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .wren_instr      (wren_instr),
    .wraddress_instr (wraddress_instr),
    .data_instr      (data_instr),
    .cpu_reset       (cpu_reset),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Every RAM write seen on the bus, plus a count of pulses wider than one cycle.
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          dbl_pulse = 0;
  logic        prev_wren = 1'b0;

  always @(negedge clk) begin
    if (wren_instr) begin
      wr_addr_q.push_back(wraddress_instr);
      wr_data_q.push_back(data_instr);
      if (prev_wren) dbl_pulse++;
    end
    prev_wren = wren_instr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_tests++;
      n_fail++;
      $error("FAIL rx_ready_wait: observed 0 expected 1 within 100 cycles");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  function automatic logic [7:0] csum_of(input logic [31:0] words[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (words[i]) c ^= words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return c;
  endfunction

  task automatic send_load(input logic [7:0] len_byte, input logic [31:0] words[$],
                           input logic [7:0] csum_byte);
    send_byte(len_byte);
    foreach (words[i]) send_word(words[i]);
    send_byte(csum_byte);
  endtask

  // Reference: word i of the image lands at address i, each exactly once.
  task automatic verify_writes(input string tag, input int base, input logic [31:0] words[$]);
    check({tag, "_count"}, wr_addr_q.size() - base, words.size());
    if (wr_addr_q.size() - base == words.size()) begin
      foreach (words[i]) begin
        check({tag, "_addr"}, wr_addr_q[base + i], i[7:0]);
        check({tag, "_data"}, wr_data_q[base + i], words[i]);
      end
    end
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] w;
    int          base, n, nwords;

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // 1: reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wren", wren_instr, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_addr", wraddress_instr, 0);
    check("rst_data", data_instr, 0);
    tick(3);
    check("idle_no_ready", rx_ready, 0);

    // 2: two-word directed load
    pulse_start();
    check("len_busy", busy, 1);
    check("len_ready", rx_ready, 1);
    base = wr_addr_q.size();
    send_byte(8'h02);
    send_word(32'h11223344);
    check("w0_wren", wren_instr, 1);
    check("w0_addr", wraddress_instr, 8'h00);
    check("w0_data", data_instr, 32'h11223344);
    check("w0_ready_low", rx_ready, 0);
    send_word(32'hAABBCCDD);
    check("w1_hold_data", data_instr, 32'hAABBCCDD);
    check("pre_csum_cpu_reset", cpu_reset, 1);
    send_byte(8'h44);
    check("ok_done", done, 1);
    check("ok_cpu_reset", cpu_reset, 0);
    check("ok_busy", busy, 0);
    check("ok_err", err, 0);
    words = '{32'h11223344, 32'hAABBCCDD};
    verify_writes("dir2", base, words);
    check("dir2_single_pulse", dbl_pulse, 0);

    // 3: same stream, bad checksum
    pulse_start();
    check("restart_cpu_reset", cpu_reset, 1);
    check("restart_done", done, 0);
    send_load(8'h02, words, 8'h45);
    check("bad_err", err, 1);
    check("bad_cpu_reset", cpu_reset, 1);
    check("bad_done", done, 0);
    tick(3);
    check("bad_err_sticky", err, 1);
    pulse_start();
    check("clr_err", err, 0);
    check("clr_busy", busy, 1);

    // 4: timeout mid-word, no partial write
    base = wr_addr_q.size();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    n = 0;
    while (!err && n < TIMEOUT + 5) begin
      @(negedge clk);
      n++;
    end
    check("to_err", err, 1);
    check("to_cycles", n, TIMEOUT);
    check("to_no_write", wr_addr_q.size() - base, 0);
    check("to_cpu_reset", cpu_reset, 1);

    // Random loads against the reference model
    for (int r = 0; r < 5; r++) begin
      nwords = $urandom_range(1, 6);
      words.delete();
      for (int i = 0; i < nwords; i++) begin
        w = $urandom();
        words.push_back(w);
      end
      base = wr_addr_q.size();
      pulse_start();
      if (r == 4) begin
        send_load(nwords[7:0], words, csum_of(words) ^ 8'h80);
        check("rnd_bad_err", err, 1);
        check("rnd_bad_cpu_reset", cpu_reset, 1);
      end else begin
        send_load(nwords[7:0], words, csum_of(words));
        check("rnd_done", done, 1);
        check("rnd_cpu_reset", cpu_reset, 0);
      end
      verify_writes("rnd", base, words);
    end

    // 5: LEN=0 means 256 words, addresses 0x00..0xFF exactly once
    words.delete();
    for (int i = 0; i < 256; i++) begin
      w = $urandom();
      words.push_back(w);
    end
    base = wr_addr_q.size();
    pulse_start();
    send_load(8'h00, words, csum_of(words));
    check("full_done", done, 1);
    check("full_cpu_reset", cpu_reset, 0);
    verify_writes("full", base, words);
    tick(5);
    check("full_no_extra", wr_addr_q.size() - base, 256);
    check("no_double_pulse", dbl_pulse, 0);

    // 6: start ignored mid-DATA, then reset aborts the load
    base = wr_addr_q.size();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'hDE);
    send_byte(8'hAD);
    pulse_start();
    check("mid_start_busy", busy, 1);
    check("mid_start_ready", rx_ready, 1);
    send_byte(8'hBE);
    send_byte(8'hEF);
    check("mid_wren", wren_instr, 1);
    check("mid_data", data_instr, 32'hDEADBEEF);
    check("mid_addr", wraddress_instr, 8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    tick(1);
    check("abort_wren", wren_instr, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", rx_ready, 0);
    check("abort_err", err, 0);
    tick(10);
    check("abort_writes", wr_addr_q.size() - base, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
